// File: rtl/czono_op_seq.sv
// Command sequencer for the constrained-zonotope operation cores.
// Commands are queued in a small FIFO, checked for legality and dimension
// overflow, then the selected core is restarted, run, and watched until it
// reports a valid result or the run timer expires.
module czono_op_seq #(
  parameter int NGMAX  = 15,
  parameter int NCMAX  = 12,
  parameter int NRMAX  = 16,
  parameter int QDEPTH = 4,
  parameter int TMO    = 4096
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [1:0]                cmd_src_i,
  input  logic [1:0]                cmd_dst_i,
  input  logic [$clog2(NGMAX)-1:0]  cmd_zng_i,
  input  logic [$clog2(NGMAX)-1:0]  cmd_yng_i,
  input  logic [$clog2(NCMAX)-1:0]  cmd_znc_i,
  input  logic [$clog2(NCMAX)-1:0]  cmd_ync_i,
  input  logic [$clog2(NRMAX)-1:0]  cmd_rnr_i,
  output logic                      core_rstn_o,
  output logic                      core_sel_o,
  output logic [1:0]                src_bank_o,
  output logic [1:0]                dst_bank_o,
  input  logic                      core_valid_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o
);

  localparam int GW  = $clog2(NGMAX);
  localparam int CW  = $clog2(NCMAX);
  localparam int RW  = $clog2(NRMAX);
  localparam int EW  = 6 + 2 * GW + 2 * CW + RW;
  localparam int AW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1;
  // Sums carry two extra bits so that no overflow can hide an oversize request.
  localparam int SGW = GW + 2;
  localparam int SCW = ((CW > RW) ? CW : RW) + 2;

  localparam logic [SGW-1:0] NG_LIM   = SGW'(NGMAX);
  localparam logic [SCW-1:0] NC_LIM   = SCW'(NCMAX);
  localparam logic [TW-1:0]  TLAST    = TW'(TMO - 1);
  localparam logic [AW:0]    QFULL    = (AW + 1)'(QDEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [EW-1:0] fifo_mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ready_en;
  logic [EW-1:0] cmd_word;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [EW-1:0] act_q;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    err_code_q;
  logic [1:0]    chk_code;
  logic          timeout_hit;

  logic [1:0]    act_op;
  logic [1:0]    act_src;
  logic [1:0]    act_dst;
  logic [GW-1:0] act_zng;
  logic [GW-1:0] act_yng;
  logic [CW-1:0] act_znc;
  logic [CW-1:0] act_ync;
  logic [RW-1:0] act_rnr;
  logic [SGW-1:0] gen_sum;
  logic [SCW-1:0] con_sum;

  assign cmd_word = {cmd_op_i, cmd_src_i, cmd_dst_i, cmd_zng_i, cmd_yng_i,
                     cmd_znc_i, cmd_ync_i, cmd_rnr_i};
  assign {act_op, act_src, act_dst, act_zng, act_yng, act_znc, act_ync, act_rnr} = act_q;

  assign full        = (count == QFULL);
  assign empty       = (count == '0);
  assign cmd_ready_o = ready_en && !full;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_q == S_IDLE) && !empty;
  assign timeout_hit = !core_valid_i && (tmo_cnt == TLAST);

  assign gen_sum = SGW'(act_zng) + SGW'(act_yng);
  assign con_sum = SCW'(act_znc) + SCW'(act_ync) + SCW'(act_rnr);

  // Ready is held off during reset and comes up on the first edge after release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ready_en <= 1'b0;
    else         ready_en <= 1'b1;
  end

  // Queue storage; contents are don't-care until written, only pointers reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= cmd_word;
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Active command register, loaded from the queue head when IDLE pops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)  act_q <= '0;
    else if (pop) act_q <= fifo_mem[rd_ptr];
  end

  // Legality check of the active command; illegal opcode takes priority.
  always_comb begin
    chk_code = 2'd0;
    if (act_op[1])
      chk_code = 2'd1;
    else if (act_src == act_dst)
      chk_code = 2'd2;
    else if ((act_op == 2'd1) && ((gen_sum > NG_LIM) || (con_sum > NC_LIM)))
      chk_code = 2'd2;
  end

  // Next-state logic of the sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_CHECK;
      S_CHECK: state_d = (chk_code != 2'd0) ? S_ERR : S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN: begin
        if (core_valid_i)     state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any running operation without a pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Run timer counts RUN cycles from zero and is cleared in every other state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                tmo_cnt <= '0;
    else if (state_q == S_RUN)  tmo_cnt <= tmo_cnt + TW'(1);
    else                        tmo_cnt <= '0;
  end

  // Error cause captured on the way into ERR, presented while err_o is high.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      err_code_q <= 2'd0;
    else if (state_q == S_CHECK)
      err_code_q <= chk_code;
    else if ((state_q == S_RUN) && timeout_hit)
      err_code_q <= 2'd3;
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);
  assign err_code_o  = err_o ? err_code_q : 2'd0;
  assign core_rstn_o = (state_q == S_RUN);
  assign core_sel_o  = (act_op == 2'd1);
  assign src_bank_o  = act_src;
  assign dst_bank_o  = act_dst;

endmodule

// File: doc/czono_op_seq.md
CZONO_OP_SEQ -- requirements
Module: czono_op_seq

Interface
REQ-001 Parameter NGMAX, default 15: maximum generator count.
REQ-002 Parameter NCMAX, default 12: maximum constraint count.
REQ-003 Parameter NRMAX, default 16: maximum output rows of the linear map R.
REQ-004 Parameter QDEPTH, default 4 (power of 2): depth of the command queue.
REQ-005 Parameter TMO, default 4096: cycle timeout of the core's RUN state.
REQ-006 clk_i  in  1  clock; all state updates on its rising edge.
REQ-007 rstn_i  in  1  reset: asynchronous, active-low.
REQ-008 cmd_valid_i  in  1  command offered.
REQ-009 cmd_ready_o  out  1  command accepted when cmd_valid_i is also high.
REQ-010 cmd_op_i  in  2  operation: 0 = LIN_IMAGE, 1 = INTERSECT, 2 and 3 are illegal.
REQ-011 cmd_src_i, cmd_dst_i  in  2 each  source and destination RAM bank indices.
REQ-012 cmd_zng_i, cmd_yng_i  in  $clog2(NGMAX) each  generator counts of Z and Y.
REQ-013 cmd_znc_i, cmd_ync_i  in  $clog2(NCMAX) each  constraint counts of Z and Y.
REQ-014 cmd_rnr_i  in  $clog2(NRMAX)  row count of R.
REQ-015 core_rstn_o  out  1  active-low restart to the operation cores.
REQ-016 core_sel_o  out  1  selected core: 0 = linear image, 1 = intersection.
REQ-017 src_bank_o, dst_bank_o  out  2 each  bank muxing for the active operation.
REQ-018 core_valid_i  in  1  valid output of the selected core.
REQ-019 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-020 done_o  out  1  one-cycle pulse on successful completion.
REQ-021 err_o  out  1  one-cycle pulse on a rejected command or a timeout.
REQ-022 err_code_o  out  2  error cause: 1 = illegal op, 2 = bank clash or dimension overflow, 3 = timeout; valid while err_o is high.

Function
REQ-023 Queue: FIFO of QDEPTH entries holding {op, src, dst, dims}.
REQ-024 A command is pushed on cmd_valid_i & cmd_ready_o.
REQ-025 cmd_ready_o = !full; no push is possible when full, even on a same-cycle pop.
REQ-026 Same-cycle push and pop with the FIFO neither full nor empty keeps the count unchanged.
REQ-027 Pointers wrap modulo QDEPTH.
REQ-028 FSM states: IDLE, CHECK, ARM, RUN, DONE, ERR.
REQ-029 IDLE: if the FIFO is not empty, pop the head into the active register and go to CHECK; otherwise stay in IDLE.
REQ-030 A command pushed at cycle T is popped no earlier than T+1.
REQ-031 CHECK goes to ERR when any of the following holds: op is 2 or 3 (code 1); src == dst (code 2); op is INTERSECT and zng+yng > NGMAX (code 2); op is INTERSECT and znc+ync+rnr > NCMAX (code 2). Otherwise CHECK goes to ARM.
REQ-032 All dimension sums in CHECK are computed at full width plus 2 bits, with no truncation.
REQ-033 ARM lasts exactly 1 cycle with core_rstn_o = 0; core_sel_o, src_bank_o and dst_bank_o are driven from the active register.
REQ-034 RUN: core_rstn_o = 1, and the outputs of REQ-033 are held stable.
REQ-035 RUN counts cycles from 0; the first cycle with core_valid_i high goes to DONE.
REQ-036 If the count reaches TMO-1 with core_valid_i still low, RUN goes to ERR (code 3).
REQ-037 core_valid_i sampled outside RUN is ignored.
REQ-038 DONE: done_o = 1 for one cycle, core_rstn_o is driven 0, next state IDLE.
REQ-039 ERR: err_o = 1 for one cycle, core_rstn_o is driven 0, the command is dropped, next state IDLE.
REQ-040 In IDLE, CHECK, DONE and ERR: core_rstn_o = 0.
REQ-041 Latency: a command accepted at T into an empty FIFO with the FSM in IDLE gives CHECK at T+2, ARM at T+3, RUN from T+4.
REQ-042 A core_valid_i first seen at cycle V in RUN gives done_o = 1 at V+1.
REQ-043 Back-to-back commands: the next pop happens in the IDLE cycle that follows DONE or ERR.
REQ-044 Commands execute strictly in FIFO order; new pushes are accepted while busy as long as the queue is not full.

Reset
REQ-045 While rstn_i is low: FIFO emptied, FSM in IDLE, timeout counter cleared.
REQ-046 While rstn_i is low: core_rstn_o = 0, core_sel_o = 0, src_bank_o = 0, dst_bank_o = 0.
REQ-047 While rstn_i is low: busy_o = 0, done_o = 0, err_o = 0, err_code_o = 0, cmd_ready_o = 0.
REQ-048 cmd_ready_o rises on the first clock edge after reset release.
REQ-049 Reset asserted during RUN aborts the operation immediately; no done_o or err_o pulse is produced.

Verification
REQ-050 LIN_IMAGE, src 0, dst 1, core_valid_i raised at the 10th RUN cycle -> core_rstn_o low 1 cycle at T+3, src_bank_o = 0, dst_bank_o = 1, done_o pulse one cycle after core_valid_i.
REQ-051 INTERSECT, zng = 8, yng = 8, NGMAX = 15 -> err_o with code 2, no ARM, FSM back in IDLE 2 cycles after CHECK.
REQ-052 Push 5 commands back-to-back with QDEPTH = 4 while the FSM is busy -> cmd_ready_o low after the 4th push, 5th accepted after the first pop, completions in push order.
REQ-053 Command with op = 3 -> err_code_o = 1; command with src == dst = 2 -> err_code_o = 2; neither asserts core_rstn_o high.
REQ-054 TMO = 16, core_valid_i held low -> err_o with code 3 after 16 RUN cycles, core_rstn_o low in the following cycle.
REQ-055 rstn_i pulsed low in RUN with 2 commands queued -> FIFO empty, busy_o = 0, no done_o, next new command runs normally.
